// File: rtl/waveform_render.sv
// Oscilloscope-style trace renderer: captures triggered microphone samples into a
// double-buffered column store and draws them as a connected line over the VGA raster.
module waveform_render #(
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 1024,
  parameter logic [11:0] WAVE_RGB     = 12'h0F0,
  parameter logic [11:0] TRIG_LEVEL   = 12'h800,
  parameter int          AUTO_TIMEOUT = 4096
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] SAMPLE,
  input  logic        SAMPLE_STB,
  input  logic        FREEZE,
  input  logic [11:0] VGA_HORZ_COORD,
  input  logic [11:0] VGA_VERT_COORD,
  output logic [3:0]  VGA_RED_WAVEFORM,
  output logic [3:0]  VGA_GREEN_WAVEFORM,
  output logic [3:0]  VGA_BLUE_WAVEFORM,
  output logic        CAPTURING,
  output logic        FRAME_VALID
);

  localparam int AW = $clog2(H_ACTIVE);
  localparam int CW = $clog2(AUTO_TIMEOUT + 1);

  typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, HOLD} state_t;

  state_t        state;
  logic [AW-1:0] wr_idx;
  logic [CW-1:0] tmo_cnt;
  logic [11:0]   prev_sample;
  logic          bank;  // bank being displayed; capture always writes the other one

  logic [9:0] ram0 [H_ACTIVE];
  logic [9:0] ram1 [H_ACTIVE];

  logic [9:0]    sample_row;
  logic          edge_trig;
  logic          tmo_trig;
  logic          trig;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          vblank;

  always_comb begin
    if ({2'b00, SAMPLE[11:2]} >= 12'(V_ACTIVE - 1)) begin
      sample_row = '0;
    end else begin
      sample_row = 10'(V_ACTIVE - 1 - int'(SAMPLE[11:2]));
    end
  end

  assign edge_trig = (prev_sample < TRIG_LEVEL) && (SAMPLE >= TRIG_LEVEL);
  assign tmo_trig  = (tmo_cnt == CW'(AUTO_TIMEOUT - 1));
  assign trig      = SAMPLE_STB && (state == WAIT_TRIG) && (edge_trig || tmo_trig);
  assign wr_en     = !RESET && (trig || (SAMPLE_STB && (state == CAPTURE)));
  assign wr_addr   = (state == CAPTURE) ? wr_idx : '0;
  assign vblank    = (VGA_VERT_COORD == 12'(V_ACTIVE)) && (VGA_HORZ_COORD == 12'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= WAIT_TRIG;
      wr_idx      <= '0;
      tmo_cnt     <= '0;
      prev_sample <= '0;
      bank        <= 1'b0;
      FRAME_VALID <= 1'b0;
      CAPTURING   <= 1'b1;
    end else begin
      if (SAMPLE_STB) prev_sample <= SAMPLE;
      case (state)
        WAIT_TRIG: begin
          if (SAMPLE_STB) begin
            if (trig) begin
              state   <= CAPTURE;
              wr_idx  <= AW'(1);
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (SAMPLE_STB) begin
            if (wr_idx == AW'(H_ACTIVE - 1)) begin
              state     <= HOLD;
              CAPTURING <= 1'b0;
              wr_idx    <= '0;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (!FREEZE && vblank) begin
            state       <= WAIT_TRIG;
            CAPTURING   <= 1'b1;
            bank        <= ~bank;
            FRAME_VALID <= 1'b1;
            tmo_cnt     <= '0;
          end
        end
        default: begin
          state     <= WAIT_TRIG;
          CAPTURING <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en && bank)  ram0[wr_addr] <= sample_row;
    if (wr_en && !bank) ram1[wr_addr] <= sample_row;
  end

  logic [AW-1:0] rd_addr;
  logic [9:0]    rd_data;
  logic [9:0]    last_data;
  logic [11:0]   horz_q;
  logic [11:0]   vert_q;
  logic [9:0]    prv;
  logic [9:0]    lo;
  logic [9:0]    hi;
  logic          lit;
  logic [11:0]   colour;

  assign rd_addr = (VGA_HORZ_COORD < 12'(H_ACTIVE)) ? AW'(VGA_HORZ_COORD) : '0;

  always_ff @(posedge CLK) begin
    rd_data   <= bank ? ram1[rd_addr] : ram0[rd_addr];
    last_data <= rd_data;
    horz_q    <= VGA_HORZ_COORD;
    vert_q    <= VGA_VERT_COORD;
  end

  // Column 0 has no left neighbour, so it draws as a single point.
  assign prv = (horz_q == 12'd0) ? rd_data : last_data;
  assign lo  = (rd_data < prv) ? rd_data : prv;
  assign hi  = (rd_data < prv) ? prv : rd_data;
  assign lit = FRAME_VALID && (horz_q < 12'(H_ACTIVE)) && (vert_q < 12'(V_ACTIVE)) &&
               ({2'b00, lo} <= vert_q) && (vert_q <= {2'b00, hi});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      colour <= '0;
    end else begin
      colour <= lit ? WAVE_RGB : 12'h000;
    end
  end

  assign VGA_RED_WAVEFORM   = colour[11:8];
  assign VGA_GREEN_WAVEFORM = colour[7:4];
  assign VGA_BLUE_WAVEFORM  = colour[3:0];

endmodule
